cmd_stream_loader: RTL
======================

// Module: cmd_stream_loader
// PURPOSE
//  Upstream feeder for the processor core's command memory. Accepts a stream of 32-bit
//  words over a valid/ready handshake and packs each group of CMD_WIDTH/WORD_WIDTH words
//  into one command. Writes each command to consecutive command-memory addresses from a
//  programmable base, driving the cmd_write_addr / cmd_write / cmd_write_enable port group.
// PARAMETERS
//  WORD_WIDTH      32   width of one input stream word (equals command-memory bank width)
//  CMD_WIDTH       128  width of one assembled command; must be a multiple of WORD_WIDTH
//  CMD_ADDR_WIDTH  16   command-memory address width
//  (derived) WPC = CMD_WIDTH/WORD_WIDTH words per command (4 at defaults)
// PORTS
//  clk               in   1               system clock; all logic on posedge
//  reset_n           in   1               asynchronous, active-low reset
//  start             in   1               one-cycle pulse: begin a load (sampled in IDLE only)
//  abort             in   1               level: terminate load, return to IDLE
//  base_addr         in   CMD_ADDR_WIDTH  first write address, latched on start
//  num_cmds          in   CMD_ADDR_WIDTH  commands to load, latched on start
//  word_in           in   WORD_WIDTH      stream data
//  word_valid        in   1               stream data valid
//  word_ready        out  1               loader accepts word_in this cycle
//  cmd_write_addr    out  CMD_ADDR_WIDTH  write address to command memory
//  cmd_write         out  CMD_WIDTH       assembled command
//  cmd_write_enable  out  1               one-cycle write strobe
//  busy              out  1               high from accepted start until return to IDLE
//  done              out  1               one-cycle pulse on completion
//  err               out  1               checksum mismatch, sticky until next start
// BEHAVIOUR
//  - Reset (reset_n low, async): state IDLE; word_ready, cmd_write_enable, busy, done, err = 0;
//    cmd_write, cmd_write_addr, word/command counters = 0. Partial command discarded.
//  - States: IDLE -> LOAD on start (latch base_addr, num_cmds; clear counters, err).
//    If num_cmds==0: IDLE -> DONE directly, no writes.
//  - LOAD: word_ready=1; word accepted when word_valid&&word_ready. Word k (0..WPC-1) of a
//    command lands in cmd_write[WORD_WIDTH*(k+1)-1 : WORD_WIDTH*k] (first word = LSBs).
//    On accepting word WPC-1 -> WRITE.
//  - WRITE (1 cycle): cmd_write_enable=1, word_ready=0, cmd_write_addr = base_addr + cmd count.
//    Next: cmd count+1; if equal to num_cmds -> CHECK (macro on) or DONE, else LOAD.
//  - DONE (1 cycle): done=1, busy=0 next cycle -> IDLE. busy=1 in LOAD/WRITE/CHECK/DONE.
//  - cmd_write / cmd_write_addr hold last written values outside WRITE.
//  - Address arithmetic modulo 2^CMD_ADDR_WIDTH: base 0xFFFF + 2 cmds writes 0xFFFF then 0x0000.
//  - start while busy is ignored. abort has priority over all transitions: next cycle IDLE,
//    no write strobe, no done, partial words dropped; abort in IDLE is a no-op.
//  - Throughput: max one command per WPC+1 cycles (WPC accepts + 1 write cycle).
// CONFIGURATION
//  CMD_STREAM_LOADER_CHECKSUM_EN defined: running XOR of every accepted data word; after last
//   WRITE enter CHECK with word_ready=1, accept one extra word; if it != XOR, err=1 (sticky);
//   then DONE. abort in CHECK -> IDLE, err unchanged.
//  Not defined: no CHECK state, no trailing word consumed; err tied to 0.
// TESTING
//  1 base=0x0010,num=2, words 0x0..0x7 valid every cycle -> strobes at 0x0010 cmd
//    0x00000003_00000002_00000001_00000000, 0x0011 cmd 0x...07_06_05_04; done 1 cycle later.
//  2 random word_valid gaps (50%) + same stream -> identical writes, no extra/missing strobes.
//  3 base=0xFFFF,num=2 -> writes at 0xFFFF then 0x0000; num=0 -> done, zero strobes.
//  4 abort after 2 words of cmd 1, then new start num=1 -> only new command written, at base.
//  5 reset_n low mid-LOAD -> all outputs 0 immediately; restart loads cleanly from word 0.
//  6 (CHECKSUM_EN) num=1 words 1,2,4,8 + trailer 0xF -> err=0; trailer 0xE -> err=1 until start.

Source files
------------

// File: rtl/cmd_stream_loader.sv
// Packs a 32-bit valid/ready word stream into wide commands and writes them to consecutive
// command-memory addresses. Optional trailing-checksum check: CMD_STREAM_LOADER_CHECKSUM_EN.
module cmd_stream_loader #(
    parameter int WORD_WIDTH     = 32,
    parameter int CMD_WIDTH      = 128,
    parameter int CMD_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CMD_ADDR_WIDTH-1:0] base_addr,
    input  logic [CMD_ADDR_WIDTH-1:0] num_cmds,
    input  logic [WORD_WIDTH-1:0]     word_in,
    input  logic                      word_valid,
    output logic                      word_ready,
    output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr,
    output logic [CMD_WIDTH-1:0]      cmd_write,
    output logic                      cmd_write_enable,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int WPC   = CMD_WIDTH / WORD_WIDTH;
    localparam int CNT_W = (WPC > 1) ? $clog2(WPC) : 1;
    localparam logic [CNT_W-1:0]          LAST_WORD = CNT_W'(WPC - 1);
    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
    localparam logic [CMD_ADDR_WIDTH-1:0] ADDR_ONE  = CMD_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                    state_reg, state_next;
    logic [CMD_ADDR_WIDTH-1:0] base_reg;
    logic [CMD_ADDR_WIDTH-1:0] num_reg;
    logic [CMD_ADDR_WIDTH-1:0] cmd_cnt_reg;
    logic [CMD_ADDR_WIDTH-1:0] cmd_cnt_inc;
    logic [CNT_W-1:0]          word_cnt_reg;
    logic [CMD_WIDTH-1:0]      buf_reg;
    logic [CMD_WIDTH-1:0]      asm_next;
    logic [CMD_WIDTH-1:0]      cmd_write_reg;
    logic [CMD_ADDR_WIDTH-1:0] addr_reg;
    logic                      accept;
    logic                      last_word;

    assign accept      = word_valid && word_ready;
    assign last_word   = (word_cnt_reg == LAST_WORD);
    assign cmd_cnt_inc = cmd_cnt_reg + ADDR_ONE;

    // The incoming word replaces exactly one lane of the partially assembled command.
    for (genvar gi = 0; gi < WPC; gi++) begin : g_lane
        assign asm_next[gi*WORD_WIDTH +: WORD_WIDTH] =
            (word_cnt_reg == CNT_W'(gi)) ? word_in : buf_reg[gi*WORD_WIDTH +: WORD_WIDTH];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = (num_cmds == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                if (accept && last_word) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (cmd_cnt_inc == num_reg) begin
`ifdef CMD_STREAM_LOADER_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_LOAD;
                end
            end
            S_CHECK: begin
                if (accept) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    // Strobes are suppressed in the abort cycle so an aborted load never writes or completes.
    assign word_ready       = (state_reg == S_LOAD) || (state_reg == S_CHECK);
    assign cmd_write_enable = (state_reg == S_WRITE) && !abort;
    assign done             = (state_reg == S_DONE) && !abort;
    assign busy             = (state_reg != S_IDLE);
    assign cmd_write        = cmd_write_reg;
    assign cmd_write_addr   = addr_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            base_reg      <= '0;
            num_reg       <= '0;
            cmd_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
            buf_reg       <= '0;
            cmd_write_reg <= '0;
            addr_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (abort) begin
                word_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            base_reg     <= base_addr;
                            num_reg      <= num_cmds;
                            cmd_cnt_reg  <= '0;
                            word_cnt_reg <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            buf_reg <= asm_next;
                            if (last_word) begin
                                word_cnt_reg  <= '0;
                                cmd_write_reg <= asm_next;
                                addr_reg      <= base_reg + cmd_cnt_reg;
                            end else begin
                                word_cnt_reg <= word_cnt_reg + CNT_ONE;
                            end
                        end
                    end
                    S_WRITE: cmd_cnt_reg <= cmd_cnt_inc;
                    default: ;
                endcase
            end
        end
    end

`ifdef CMD_STREAM_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] xor_reg;
    logic                  err_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xor_reg <= '0;
            err_reg <= 1'b0;
        end else if (!abort) begin
            if (state_reg == S_IDLE && start) begin
                xor_reg <= '0;
                err_reg <= 1'b0;
            end else if (state_reg == S_LOAD && accept) begin
                xor_reg <= xor_reg ^ word_in;
            end else if (state_reg == S_CHECK && accept) begin
                if (word_in != xor_reg) err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule
